// File: rtl/mdio_pkg.sv
// mdio_pkg: clause-22 MDIO frame constants, command/status field positions and FSM states
package mdio_pkg;
    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam int CMD_NOPRE = 29;
    localparam int CMD_RD    = 28;
    localparam int CMD_PHY   = 23;
    localparam int CMD_REG   = 18;
    localparam int STAT_BUSY = 31;
    localparam int STAT_RDV  = 30;
    localparam int STAT_OVR  = 29;
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_END} state_t;
    // Read frames fill TA and DATA with ones; those bits are never driven.
    function automatic logic [63:0] build_frame(input logic rd, input logic [4:0] phy,
                                                input logic [4:0] regad, input logic [15:0] wdata);
        return {32'hFFFF_FFFF, ST, rd ? OP_READ : OP_WRITE, phy, regad,
                rd ? 2'b11 : 2'b10, rd ? 16'hFFFF : wdata};
    endfunction
endpackage

// File: rtl/mdio_tick.sv
// mdio_tick: MDC divider, toggles every CLK_DIV cycles while running, with rise/fall strobes
module mdio_tick #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rstn,
    input  logic run_i,
    input  logic clr_i,
    input  logic hold_i,
    output logic mdc_o,
    output logic rise_o,
    output logic fall_o,
    output logic tc_o
);
    logic [7:0] cnt_q, cnt_d;
    logic       mdc_q, mdc_d, tog;
    assign tc_o   = run_i && cnt_q == 8'(CLK_DIV - 1);
    assign tog    = tc_o && !hold_i;
    assign rise_o = tog && !mdc_q;
    assign fall_o = tog && mdc_q;
    assign mdc_o  = mdc_q;
    always_comb begin
        cnt_d = clr_i ? 8'd0 : tc_o ? 8'd0 : run_i ? cnt_q + 8'd1 : cnt_q;
        mdc_d = clr_i ? 1'b0 : tog ? !mdc_q : mdc_q;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end
endmodule

// File: rtl/lb_mdio_master.sv
// lb_mdio_master: local-bus slave running clause-22 MDIO frames to the PHY.
// Define MDIO_PREAMBLE_SUPPRESS_EN to honour command bit 29 (skip the 32-bit preamble).
module lb_mdio_master
    import mdio_pkg::*;
#(
    parameter int          CLK_DIV   = 25,
    parameter logic [23:0] BASE_ADDR = 24'h000040
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [23:0] addr,
    input  logic        control_strobe,
    input  logic        control_rd,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i,
    output logic        busy
);
    state_t      state_q, state_d;
    logic [5:0]  bit_q, bit_d;
    logic [63:0] frame_q, frame_d, full_w, frame_w;
    logic [31:0] cmd_q, cmd_d, din_q, din_d, cmd_w, stat;
    logic [15:0] rdd_q, rdd_d;
    logic        oe_q, oe_d, busy_q, busy_d, rdv_q, rdv_d, ovr_q, ovr_d;
    logic        wr_cmd, rd_cmd, rd_stat, start, nopre_w, rise, fall, tc;
    assign wr_cmd  = control_strobe && !control_rd && addr == BASE_ADDR;
    assign rd_cmd  = control_strobe && control_rd && addr == BASE_ADDR;
    assign rd_stat = control_strobe && control_rd && addr == BASE_ADDR + 24'd1;
    assign start   = wr_cmd && !busy_q;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    assign cmd_w   = data_out;
    assign nopre_w = data_out[CMD_NOPRE];
`else
    assign cmd_w   = data_out & ~(32'd1 << CMD_NOPRE);
    assign nopre_w = 1'b0;
`endif
    assign full_w  = build_frame(cmd_w[CMD_RD], cmd_w[CMD_PHY +: 5], cmd_w[CMD_REG +: 5], cmd_w[15:0]);
    assign frame_w = nopre_w ? {full_w[31:0], 32'hFFFF_FFFF} : full_w;
    mdio_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk(clk), .rstn(rstn), .run_i(busy_q), .clr_i(start), .hold_i(state_q == S_END),
        .mdc_o(mdc), .rise_o(rise), .fall_o(fall), .tc_o(tc)
    );
    always_comb begin
        stat = {16'd0, rdd_q};
        stat[STAT_BUSY] = busy_q;
        stat[STAT_RDV]  = rdv_q;
        stat[STAT_OVR]  = ovr_q;
    end
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        cmd_d   = cmd_q;
        din_d   = din_q;
        rdd_d   = rdd_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        rdv_d   = rdv_q;
        ovr_d   = ovr_q;
        if (start) begin
            cmd_d   = cmd_w;
            frame_d = frame_w;
            oe_d    = 1'b1;
            busy_d  = 1'b1;
            bit_d   = nopre_w ? 6'd32 : 6'd0;
            state_d = nopre_w ? S_HDR : S_PRE;
        end
        if (wr_cmd && busy_q) ovr_d = 1'b1;
        // Bit index is frame-absolute, so a suppressed preamble simply starts at 32.
        if (fall) begin
            frame_d = {frame_q[62:0], 1'b1};
            bit_d   = bit_q + 6'd1;
            state_d = bit_q == 6'd31 ? S_HDR : bit_q == 6'd45 ? S_TA :
                      bit_q == 6'd47 ? S_DATA : bit_q == 6'd63 ? S_END : state_q;
            if (bit_q == 6'd45 && cmd_q[CMD_RD]) oe_d = 1'b0;
            if (bit_q == 6'd63) begin
                frame_d = '1;
                oe_d    = 1'b0;
            end
        end
        if (rise && state_q == S_DATA && cmd_q[CMD_RD]) rdd_d = {rdd_q[14:0], mdio_i};
        if (state_q == S_END && tc) state_d = S_IDLE;
        if (rd_stat) begin
            din_d = stat;
            rdv_d = 1'b0;
            ovr_d = 1'b0;
        end
        if (rd_cmd) din_d = cmd_q;
        // One trailing idle cycle with busy still high completes the frame.
        if (state_q == S_IDLE && busy_q) begin
            busy_d = 1'b0;
            if (cmd_q[CMD_RD]) rdv_d = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            frame_q <= '1;
            cmd_q   <= '0;
            din_q   <= '0;
            rdd_q   <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            rdv_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            cmd_q   <= cmd_d;
            din_q   <= din_d;
            rdd_q   <= rdd_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            rdv_q   <= rdv_d;
            ovr_q   <= ovr_d;
        end
    end
    assign data_in = din_q;
    assign mdio_o  = frame_q[63];
    assign mdio_oe = oe_q;
    assign busy    = busy_q;
endmodule
